stall_flush_ctrl: RTL and testbench
===================================

STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 200, meaning the max MEM_WAIT cycles before watchdog release (1..2^TO_W-1).
REQ-002 SHALL have parameter TO_W, default 8, meaning the watchdog counter width.
REQ-003 SHALL have ports: clk_i  in  1  clock, rising edge; rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port lu_hazard_i  in  1  load-use hazard detected (EX load rd matches ID rs1/rs2).
REQ-005 SHALL have port branch_flush_i  in  1  branch/jump taken, resolved in ID.
REQ-006 SHALL have port mem_req_i  in  1  MEM stage has an outstanding slow data-memory access.
REQ-007 SHALL have port mem_ack_i  in  1  data memory completes this cycle.
REQ-008 SHALL have outputs: pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o  out  1 each  stage write/flush/hold controls.
REQ-009 SHALL have outputs: state_o  out  2  current FSM state; err_o  out  1  sticky watchdog error.
REQ-010 SHALL have STALL_CNT_EN-only outputs lu_cnt_o, mem_cnt_o, flush_cnt_o  out  32 each  event counters.

Function
REQ-011 SHALL implement FSM states RUN=2'b00 and MEM_WAIT=2'b01, registered, with state_o equal to the state register.
REQ-012 SHALL drive all control outputs combinationally from state and current inputs, with zero-cycle latency.
REQ-013 In RUN with mem_req_i=1 and mem_ack_i=0, SHALL assert pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, and move to MEM_WAIT at the next edge.
REQ-014 In RUN with mem_req_i=1 and mem_ack_i=1 (zero-wait access), SHALL not stall and SHALL stay in RUN.
REQ-015 In MEM_WAIT, SHALL keep the freeze of REQ-013 while mem_ack_i=0; when mem_ack_i=1, SHALL release (normal-RUN outputs) that cycle and return to RUN.
REQ-016 In RUN with no memory stall and lu_hazard_i=1, SHALL set pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
REQ-017 In RUN with no memory stall, lu_hazard_i=0 and branch_flush_i=1, SHALL set ifid_flush_o=1 with pc_write_o=1 and ifid_write_o=1.
REQ-018 SHALL apply the priority memory stall > load-use > branch flush; the lower-priority inputs stay held upstream and are re-evaluated after release.
REQ-019 In RUN with no event, SHALL set pc_write_o=1, ifid_write_o=1 and all other control outputs to 0.
REQ-020 SHALL clear the watchdog counter on entry to MEM_WAIT and increment it once per MEM_WAIT cycle with mem_ack_i=0.
REQ-021 SHALL, when the watchdog count reaches MEM_TIMEOUT, set err_o=1 (sticky until reset), force release for that cycle, and return to RUN.
REQ-022 SHALL ignore mem_ack_i in RUN when mem_req_i=0.

Reset
REQ-023 SHALL, while rst_i=1, immediately (asynchronously) set state=RUN, watchdog=0, err_o=0 and all counters=0.
REQ-024 During reset SHALL drive pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, ifid_flush_o=0 and idex_bubble_o=0.
REQ-025 SHALL abandon MEM_WAIT if reset occurs mid-wait, with no pending state retained.

Configuration
REQ-026 When STALL_CNT_EN is defined, SHALL count each load-use stall cycle (REQ-016), each MEM_WAIT freeze cycle, and each flush cycle (REQ-017), each counter saturating at 32'hFFFFFFFF.
REQ-027 When STALL_CNT_EN is undefined, SHALL omit the counters and ports entirely, with all other behaviour identical.

Verification
REQ-028 After reset release with all inputs 0, SHALL give pc_write_o=1, ifid_write_o=1, state_o=00 and err_o=0.
REQ-029 lu_hazard_i=1 for 1 cycle SHALL give exactly 1 cycle of pc_write_o=0, idex_bubble_o=1; lu_cnt_o=1 with STALL_CNT_EN.
REQ-030 mem_req_i=1 with mem_ack_i at cycle 4 SHALL give pipe_hold_o=1 for 3 cycles (state_o=01 for 3 cycles), release in the ack cycle, then state_o=00.
REQ-031 lu_hazard_i=1 and branch_flush_i=1 together in RUN SHALL give idex_bubble_o=1 and ifid_flush_o=0; mem_req_i added in the same cycle SHALL give pipe_hold_o=1 and idex_bubble_o=0.
REQ-032 With MEM_TIMEOUT=5, mem_req_i high and no ack SHALL give release at the 5th MEM_WAIT cycle, then err_o=1 held until rst_i.
REQ-033 rst_i asserted during MEM_WAIT mid-cycle SHALL give state_o=00, err_o=0 and counters=0 before the next clock edge.

Source files
------------

// File: rtl/stall_flush_ctrl.sv
// -----------------------------------------------------------------------------
// stall_flush_ctrl
//
// Purpose:
//    Hazard/stall/flush controller for a 5-stage in-order pipeline. It
//    arbitrates three event sources with the fixed priority
//       memory stall  >  load-use hazard  >  branch flush
//    and drives the per-stage write/flush/hold controls combinationally from
//    the current FSM state and the current inputs (zero-cycle latency).
//
//    A slow data-memory access freezes the whole pipeline. The first frozen
//    cycle is spent in RUN and the remaining ones in MEM_WAIT. A watchdog
//    counts MEM_WAIT cycles without an acknowledge. When it reaches
//    MEM_TIMEOUT, the pipeline is released for that cycle and a sticky error
//    flag is raised.
//
// Parameters:
//    MEM_TIMEOUT  maximum MEM_WAIT cycles before watchdog release (1..2^TO_W-1)
//    TO_W         watchdog counter width
//
// Ports:
//    clk_i           in   1   clock, rising edge
//    rst_i           in   1   asynchronous, active-high reset
//    lu_hazard_i     in   1   load-use hazard (EX load rd matches ID rs1/rs2)
//    branch_flush_i  in   1   branch/jump taken, resolved in ID
//    mem_req_i       in   1   MEM stage has an outstanding slow access
//    mem_ack_i       in   1   data memory completes this cycle
//    pc_write_o      out  1   PC register write enable
//    ifid_write_o    out  1   IF/ID register write enable
//    ifid_flush_o    out  1   IF/ID flush (kill wrong-path fetch)
//    idex_bubble_o   out  1   insert a bubble into ID/EX
//    pipe_hold_o     out  1   freeze every pipeline stage
//    state_o         out  2   current FSM state (00 = RUN, 01 = MEM_WAIT)
//    err_o           out  1   sticky watchdog error
//    lu_cnt_o        out  32  load-use stall cycles    (STALL_CNT_EN only)
//    mem_cnt_o       out  32  memory freeze cycles     (STALL_CNT_EN only)
//    flush_cnt_o     out  32  branch flush cycles      (STALL_CNT_EN only)
//
// Configuration:
//    Define the macro STALL_CNT_EN to build the three saturating event
//    counters and their ports. When the macro is undefined, the counters and
//    ports are absent, and all other behaviour is identical.
// -----------------------------------------------------------------------------
module stall_flush_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 200,
   parameter int unsigned TO_W        = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lu_hazard_i,
   input  logic        branch_flush_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        pipe_hold_o,
   output logic [1:0]  state_o,
   output logic        err_o
`ifdef STALL_CNT_EN
   ,
   output logic [31:0] lu_cnt_o,
   output logic [31:0] mem_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01
   } state_t;

   state_t          r_state;
   logic [TO_W-1:0] r_wd_cnt;
   logic            r_err;

   logic            w_timeout;
   logic            w_mem_stall;

   // The watchdog expires on the MEM_WAIT cycle whose increment would make the
   // count reach MEM_TIMEOUT. That cycle is released immediately rather than
   // one cycle later.
   assign w_timeout = (r_state == MEM_WAIT) && !mem_ack_i &&
                      (r_wd_cnt == TO_W'(MEM_TIMEOUT - 1));

   // A freeze is needed when an access is outstanding and not completing now.
   // In RUN, an acknowledge without a request is meaningless and is ignored.
   // In MEM_WAIT, an acknowledge or an expired watchdog releases the pipeline.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      w_mem_stall = 1'b0;
      if (!rst_i) begin
         case (r_state)
            RUN:      w_mem_stall = mem_req_i && !mem_ack_i;
            MEM_WAIT: w_mem_stall = !mem_ack_i && !w_timeout;
            default:  w_mem_stall = 1'b0;
         endcase
      end
   end

   // Stage controls. The lower-priority events are simply masked. The
   // upstream logic keeps them asserted, so they are re-evaluated once the
   // higher-priority condition clears.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_hold_o   = 1'b0;
      if (rst_i || w_mem_stall) begin
         // Reset looks like a full freeze to the rest of the pipeline.
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         pipe_hold_o  = 1'b1;
      end else if (lu_hazard_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_flush_i) begin
         ifid_flush_o = 1'b1;
      end
   end

   // State, watchdog and sticky error. A reset in the middle of a wait drops
   // straight back to RUN and leaves nothing pending.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= RUN;
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // right-hand side reads the pre-edge value.
         case (r_state)
            RUN: begin
               if (mem_req_i && !mem_ack_i) begin
                  r_state  <= MEM_WAIT;
                  r_wd_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (mem_ack_i) begin
                  r_state <= RUN;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
                  if (w_timeout) begin
                     r_err   <= 1'b1;
                     r_state <= RUN;
                  end
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign state_o = r_state;
   assign err_o   = r_err;

`ifdef STALL_CNT_EN
   // Event counters sample the decoded controls. Each counter sticks at all
   // ones instead of wrapping. mem_cnt_o counts every frozen cycle of a
   // memory stall, including the RUN cycle that starts the wait.
   logic [31:0] r_lu_cnt;
   logic [31:0] r_mem_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lu_cnt    <= '0;
         r_mem_cnt   <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (idex_bubble_o && (r_lu_cnt != 32'hFFFF_FFFF))
            r_lu_cnt <= r_lu_cnt + 32'd1;
         if (w_mem_stall && (r_mem_cnt != 32'hFFFF_FFFF))
            r_mem_cnt <= r_mem_cnt + 32'd1;
         if (ifid_flush_o && (r_flush_cnt != 32'hFFFF_FFFF))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign lu_cnt_o    = r_lu_cnt;
   assign mem_cnt_o   = r_mem_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_flush_ctrl
//
// Table-driven, self-checking bench for stall_flush_ctrl, built with
// MEM_TIMEOUT = 5. Each step drives one cycle of inputs shortly after the
// rising edge. The expected control vector for that cycle is queued at the
// same time, then popped and compared on the falling edge.
//
// Expected vector layout:
//    {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state[1:0], err}
// -----------------------------------------------------------------------------
module tb_stall_flush_ctrl;

   localparam int unsigned MEM_TIMEOUT = 5;
   localparam int unsigned TO_W        = 8;

   // Expected patterns used throughout the tables below.
   localparam logic [7:0] E_FREEZE_RUN = 8'b0000_1000; // reset, or RUN freeze
   localparam logic [7:0] E_FREEZE_MW  = 8'b0000_1010; // freeze in MEM_WAIT
   localparam logic [7:0] E_NORM       = 8'b1100_0000; // RUN, no event
   localparam logic [7:0] E_NORM_MW    = 8'b1100_0010; // release in MEM_WAIT
   localparam logic [7:0] E_BUBBLE     = 8'b0001_0000; // load-use in RUN
   localparam logic [7:0] E_BUBBLE_MW  = 8'b0001_0010; // load-use at release
   localparam logic [7:0] E_FLUSH      = 8'b1110_0000; // branch flush in RUN

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        lu_hazard_i = 1'b0;
   logic        branch_flush_i = 1'b0;
   logic        mem_req_i = 1'b0;
   logic        mem_ack_i = 1'b0;
   logic        pc_write_o;
   logic        ifid_write_o;
   logic        ifid_flush_o;
   logic        idex_bubble_o;
   logic        pipe_hold_o;
   logic [1:0]  state_o;
   logic        err_o;
`ifdef STALL_CNT_EN
   logic [31:0] lu_cnt_o;
   logic [31:0] mem_cnt_o;
   logic [31:0] flush_cnt_o;
   int unsigned e_lu    = 0;
   int unsigned e_mem   = 0;
   int unsigned e_flush = 0;
`endif

   typedef struct {
      string      tag;
      logic       rst;
      logic [7:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        n_checks = 0;
   int        n_fail   = 0;

   stall_flush_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .lu_hazard_i    (lu_hazard_i),
      .branch_flush_i (branch_flush_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_bubble_o  (idex_bubble_o),
      .pipe_hold_o    (pipe_hold_o),
      .state_o        (state_o),
      .err_o          (err_o)
`ifdef STALL_CNT_EN
      ,
      .lu_cnt_o       (lu_cnt_o),
      .mem_cnt_o      (mem_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive {rst, lu, br, req, ack} after the edge, queue the
   // expectation, and compare on the falling edge.
   task automatic step(input string tag, input logic [4:0] drv,
                       input logic [7:0] exp);
      sb_entry_t e;
      @(posedge clk_i);
      #1;
      {rst_i, lu_hazard_i, branch_flush_i, mem_req_i, mem_ack_i} = drv;
      e.tag = tag;
      e.rst = drv[4];
      e.exp = exp;
      sb_q.push_back(e);
      @(negedge clk_i);
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, {24'd0, pc_write_o, ifid_write_o, ifid_flush_o,
                       idex_bubble_o, pipe_hold_o, state_o, err_o},
               {24'd0, e.exp});
`ifdef STALL_CNT_EN
         if (e.rst) begin
            e_lu = 0; e_mem = 0; e_flush = 0;
         end
         check({e.tag, "_lu_cnt"},    lu_cnt_o,    e_lu);
         check({e.tag, "_mem_cnt"},   mem_cnt_o,   e_mem);
         check({e.tag, "_flush_cnt"}, flush_cnt_o, e_flush);
         if (!e.rst) begin
            if (e.exp[4]) e_lu++;
            if (e.exp[3]) e_mem++;
            if (e.exp[5]) e_flush++;
         end
`endif
      end
   endtask

   initial begin
      // Reset: full freeze regardless of the other inputs.
      step("rst_idle",      5'b1_0000, E_FREEZE_RUN);
      step("rst_inputs",    5'b1_1110, E_FREEZE_RUN);
      // Out of reset with all inputs low.
      step("run_idle",      5'b0_0000, E_NORM);
      // A single-cycle load-use hazard gives exactly one bubble.
      step("lu_one",        5'b0_1000, E_BUBBLE);
      step("lu_after",      5'b0_0000, E_NORM);
      // Branch flush.
      step("br_flush",      5'b0_0100, E_FLUSH);
      // Load-use beats branch, and a memory stall beats both.
      step("lu_br",         5'b0_1100, E_BUBBLE);
      step("mem_lu_br",     5'b0_1110, E_FREEZE_RUN);
      step("mw_ack_rel",    5'b0_0011, E_NORM_MW);
      step("after_rel",     5'b0_0000, E_NORM);
      // Ack on cycle 4: three frozen cycles, three cycles in MEM_WAIT.
      step("mw4_c1",        5'b0_0010, E_FREEZE_RUN);
      step("mw4_c2",        5'b0_0010, E_FREEZE_MW);
      step("mw4_c3",        5'b0_0010, E_FREEZE_MW);
      step("mw4_ack",       5'b0_0011, E_NORM_MW);
      step("mw4_done",      5'b0_0000, E_NORM);
      // Zero-wait access does not stall, and a stray ack is ignored.
      step("zero_wait",     5'b0_0011, E_NORM);
      step("zero_wait_nx",  5'b0_0000, E_NORM);
      step("stray_ack",     5'b0_0001, E_NORM);
      // Pending lower-priority events are held during the wait and
      // re-evaluated at release.
      step("hold_lu_c1",    5'b0_1010, E_FREEZE_RUN);
      step("hold_br_mw",    5'b0_0110, E_FREEZE_MW);
      step("rel_lu",        5'b0_1011, E_BUBBLE_MW);
      step("rel_lu_done",   5'b0_0000, E_NORM);
      // Watchdog: release on the 5th MEM_WAIT cycle, then sticky err.
      step("to_entry",      5'b0_0010, E_FREEZE_RUN);
      step("to_mw1",        5'b0_0010, E_FREEZE_MW);
      step("to_mw2",        5'b0_0010, E_FREEZE_MW);
      step("to_mw3",        5'b0_0010, E_FREEZE_MW);
      step("to_mw4",        5'b0_0010, E_FREEZE_MW);
      step("to_release",    5'b0_0010, E_NORM_MW);
      step("err_set",       5'b0_0000, E_NORM | 8'd1);
      step("err_hold",      5'b0_0000, E_NORM | 8'd1);
      step("err_mw_c1",     5'b0_0010, E_FREEZE_RUN | 8'd1);
      step("err_mw_ack",    5'b0_0011, E_NORM_MW | 8'd1);
      step("err_sticky",    5'b0_0000, E_NORM | 8'd1);
      // Asynchronous reset in the middle of MEM_WAIT, sampled before any
      // further clock edge.
      step("rw_entry",      5'b0_0010, E_FREEZE_RUN | 8'd1);
      step("rw_mw",         5'b0_0010, E_FREEZE_MW | 8'd1);
      step("rst_mid_wait",  5'b1_0010, E_FREEZE_RUN);
      step("post_rst",      5'b0_0000, E_NORM);
      step("post_rst_lu",   5'b0_1000, E_BUBBLE);
      step("post_rst_idle", 5'b0_0000, E_NORM);
      if (sb_q.size() != 0)
         check("sb_leftover", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
